mem_req_bridge: RTL and testbench
=================================

Name: mem_req_bridge

Overview:
- Converts a core-side valid/ready load/store request stream into the simple dual-port memory interface used by the testbench memory model.
- Memory interface: write enable/address/data/byte-enable, plus read address in and read data back.
- Handles byte/half/word sizing, write-lane replication, byte enables, read latency of 0 or 1 cycle, load alignment and sign extension, and misalignment errors.
- Sits between the core's data-side request port and the memory model; one outstanding request at a time.

Parameters:
- AWIDTH, 10, memory word-address width; the byte address is AWIDTH+2 bits.
- RD_LATENCY, 0, memory read latency in cycles. Must be 0 (combinational memory output) or 1 (flopped output); any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  AWIDTH+2  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  zero-extend loads when 1
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  aligned and extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request
- mem_wren  out  1  memory write enable
- mem_wraddr  out  AWIDTH  memory write word address
- mem_wrdata  out  32  memory write data
- mem_wrben  out  4  memory byte enables
- mem_rdaddr  out  AWIDTH  memory read word address
- mem_rddata  in  32  memory read data

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - req_ready = 1 (it is 1 only in IDLE).
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - mem_rdaddr register = 0, mem_wren = 0.
- Reset asserted mid-operation: abandons any in-flight request. No memory write occurs after reset asserts, and no response is produced for that request.
- States: IDLE, RD_WAIT (present only when RD_LATENCY = 1), RD_CAP, RESP.
- Accept: a request is accepted on a cycle where req_valid && req_ready. Its addr, size and unsigned fields are latched.
- Alignment check at accept:
  - Misaligned means size = 1 with addr[0] = 1, size = 2 with addr[1:0] != 0, or size = 3.
  - A misaligned request makes no memory access, sets rsp_err = 1 and rsp_rdata = 0, and goes to RESP.
- Store path:
  - mem_wren is combinational: req_valid && req_ready && req_we && aligned.
  - mem_wraddr = req_addr[AWIDTH+1:2].
  - Write data and enables by size:
    - byte: mem_wrdata = {4{wdata[7:0]}}, mem_wrben = 4'b0001 << addr[1:0].
    - half: mem_wrdata = {2{wdata[15:0]}}, mem_wrben = 4'b0011 << addr[1:0].
    - word: mem_wrdata = wdata, mem_wrben = 4'hF.
  - When mem_wren = 0, mem_wrben = 0.
  - Next state is RESP, with rsp_rdata = 0 and rsp_err = 0.
- Load path:
  - On accept, the registered mem_rdaddr is set to the word address.
  - RD_LATENCY = 0: IDLE → RD_CAP.
  - RD_LATENCY = 1: IDLE → RD_WAIT → RD_CAP.
  - RD_CAP samples mem_rddata, extracts the lane at addr[1:0], sign- or zero-extends it, registers the result into rsp_rdata, then goes to RESP.
  - mem_rdaddr holds its value outside loads.
- Latency from accept to rsp_valid:
  - stores and errors: 1 cycle.
  - loads: 2 cycles (RD_LATENCY = 0) or 3 cycles (RD_LATENCY = 1).
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready cycle: go to IDLE and clear rsp_valid.
  - No new request is accepted in that same cycle; peak throughput is one request per 2 cycles.
- Simultaneous events: req_valid is ignored outside IDLE. req_* fields need only be stable on the accept cycle.

Decomposition:
- Package mem_bridge_pkg:
  - typedef enum logic [1:0] mem_size_e {SIZE_B, SIZE_H, SIZE_W, SIZE_X}.
  - state enum bridge_state_e.
  - constants DWIDTH = 32 and DBYTES = 4.
  - function is_aligned(addr_lo, size).
- One combinational sub-module, load_align:
  - inputs rddata[31:0], addr_lo[1:0], size, unsigned.
  - output rdata[31:0] (lane extraction plus extension).
  - Shared with the future core LSU.

Test Plan:
- Store word 0xDEADBEEF to addr 0x010, then load word from 0x010: mem_wrben = 4'hF, mem_wraddr = 4, rsp_rdata = 0xDEADBEEF, rsp_err = 0. Load rsp_valid arrives 2 cycles after accept with RD_LATENCY = 0 and 3 cycles with RD_LATENCY = 1.
- Store byte 0x80 to addr 0x013: mem_wrben = 4'b1000, mem_wrdata = 0x80808080. A signed byte load at 0x013 returns 0xFFFFFF80; an unsigned one returns 0x00000080.
- Store half 0x8001 to addr 0x022: mem_wrben = 4'b1100. A signed half load returns 0xFFFF8001; an unsigned one returns 0x00008001.
- Half load from 0x021, word store to 0x012, and size = 3: mem_wren stays 0, mem_rdaddr is unchanged, and rsp_err = 1 with rsp_rdata = 0 one cycle after accept.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a load response. rsp_valid and rsp_rdata stay stable and req_ready = 0 throughout; the cycle after the handshake, req_ready = 1.
- Assert rst_n low in RD_WAIT during a load, then release. rsp_valid stays 0, state is IDLE, and no response or write appears. A following store completes normally.

Source files
------------

// File: rtl/mem_req_bridge_pkg.sv
// Shared types and helpers for the memory request bridge and the core LSU.
// Contents:
//   mem_size_e     - access size encoding carried on req_size
//   bridge_state_e - bridge control states
//   DWIDTH/DBYTES  - data path width in bits and bytes
//   is_aligned()   - natural-alignment check for an access size
package mem_bridge_pkg;

    localparam int DWIDTH = 32;
    localparam int DBYTES = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_CAP  = 2'd2,
        ST_RESP    = 2'd3
    } bridge_state_e;

    // True when the access is naturally aligned; the illegal size never is.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input mem_size_e size);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~addr_lo[0];
            SIZE_W:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_req_bridge_load_align.sv
// Load data alignment: picks the addressed lane out of a memory word and
// sign- or zero-extends it to 32 bits.
// Ports:
//   rddata[31:0] in  - raw memory word
//   addr_lo[1:0] in  - byte offset of the access within the word
//   size         in  - access size (mem_size_e)
//   is_unsigned  in  - 1 = zero-extend, 0 = sign-extend
//   rdata[31:0]  out - right-aligned, extended load value (0 for illegal size)
module load_align
    import mem_bridge_pkg::*;
(
    input  logic [31:0] rddata,
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] lane_s;

    // Shift the addressed byte lane down to bit 0.
    assign lane_s = rddata >> {addr_lo, 3'b000};

    // Extend the lane according to the access size.
    always_comb begin
        rdata = 32'h0000_0000;
        case (size)
            SIZE_B:  rdata = is_unsigned ? {24'h00_0000, lane_s[7:0]}
                                         : {{24{lane_s[7]}}, lane_s[7:0]};
            SIZE_H:  rdata = is_unsigned ? {16'h0000, lane_s[15:0]}
                                         : {{16{lane_s[15]}}, lane_s[15:0]};
            SIZE_W:  rdata = rddata;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_req_bridge.sv
// Bridges a valid/ready load/store request stream onto a simple dual-port
// memory (write port plus read-address / read-data port). One request is in
// flight at a time; every request returns one response.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   req_valid/req_ready              - request handshake
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata          - request fields (stable on accept only)
//   rsp_valid/rsp_ready              - response handshake
//   rsp_rdata, rsp_err               - load data / misalignment flag
//   mem_wren, mem_wraddr, mem_wrdata,
//   mem_wrben                        - memory write port (combinational)
//   mem_rdaddr, mem_rddata           - memory read port (address registered)
module mem_req_bridge
    import mem_bridge_pkg::*;
#(
    parameter int AWIDTH     = 10,
    parameter int RD_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wren,
    output logic [AWIDTH-1:0] mem_wraddr,
    output logic [31:0]       mem_wrdata,
    output logic [3:0]        mem_wrben,
    output logic [AWIDTH-1:0] mem_rdaddr,
    input  logic [31:0]       mem_rddata
);

    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
        $error("mem_req_bridge: RD_LATENCY must be 0 or 1");
    end

    bridge_state_e     state_r;
    bridge_state_e     state_next_s;
    mem_size_e         size_s;
    logic              aligned_s;
    logic              accept_s;
    logic [1:0]        addr_lo_r;
    mem_size_e         size_r;
    logic              unsigned_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;
    logic [AWIDTH-1:0] mem_rdaddr_r;
    logic [31:0]       align_rdata_s;

    assign size_s    = mem_size_e'(req_size);
    assign aligned_s = is_aligned(req_addr[1:0], size_s);
    assign accept_s  = req_valid && (state_r == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: errors and stores answer directly, loads pass through the capture state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!aligned_s || req_we) begin
                        state_next_s = ST_RESP;
                    end else if (RD_LATENCY == 1) begin
                        state_next_s = ST_RD_WAIT;
                    end else begin
                        state_next_s = ST_RD_CAP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: state_next_s = ST_RD_CAP;
            ST_RD_CAP:  state_next_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake flags and the write port; stores write during the accept cycle itself.
    always_comb begin
        req_ready  = (state_r == ST_IDLE);
        rsp_valid  = (state_r == ST_RESP);
        mem_wren   = accept_s && req_we && aligned_s;
        mem_wraddr = req_addr[AWIDTH+1:2];
        mem_wrdata = req_wdata;
        mem_wrben  = 4'b0000;
        case (size_s)
            SIZE_B: begin
                mem_wrdata = {4{req_wdata[7:0]}};
                mem_wrben  = mem_wren ? (4'b0001 << req_addr[1:0]) : 4'b0000;
            end
            SIZE_H: begin
                mem_wrdata = {2{req_wdata[15:0]}};
                mem_wrben  = mem_wren ? (4'b0011 << req_addr[1:0]) : 4'b0000;
            end
            SIZE_W: begin
                mem_wrdata = req_wdata;
                mem_wrben  = mem_wren ? 4'b1111 : 4'b0000;
            end
            default: begin
                mem_wrdata = req_wdata;
                mem_wrben  = 4'b0000;
            end
        endcase
    end

    load_align u_load_align (
        .rddata      (mem_rddata),
        .addr_lo     (addr_lo_r),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .rdata       (align_rdata_s)
    );

    // Request latch, read address and response payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_r    <= 2'b00;
            size_r       <= SIZE_B;
            unsigned_r   <= 1'b0;
            rsp_rdata_r  <= 32'h0000_0000;
            rsp_err_r    <= 1'b0;
            mem_rdaddr_r <= '0;
        end else if (accept_s) begin
            addr_lo_r   <= req_addr[1:0];
            size_r      <= size_s;
            unsigned_r  <= req_unsigned;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= !aligned_s;
            // Only a good load moves the read address; errors leave it untouched.
            if (aligned_s && !req_we) begin
                mem_rdaddr_r <= req_addr[AWIDTH+1:2];
            end
        end else if (state_r == ST_RD_CAP) begin
            rsp_rdata_r <= align_rdata_s;
        end
    end

    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign mem_rdaddr = mem_rdaddr_r;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Self-checking bench: one bridge with RD_LATENCY = 0 and one with
// RD_LATENCY = 1 receive identical requests; each has its own memory model,
// and all responses are compared against a byte-addressed reference memory.
module tb_mem_req_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready_0, rsp_valid_0, rsp_err_0, mem_wren_0;
    logic [31:0] rsp_rdata_0, mem_wrdata_0, mem_rddata_0;
    logic [9:0]  mem_wraddr_0, mem_rdaddr_0;
    logic [3:0]  mem_wrben_0;
    logic        req_ready_1, rsp_valid_1, rsp_err_1, mem_wren_1;
    logic [31:0] rsp_rdata_1, mem_wrdata_1, mem_rddata_1;
    logic [9:0]  mem_wraddr_1, mem_rdaddr_1;
    logic [3:0]  mem_wrben_1;

    bit [31:0]    mem0 [1024];
    bit [31:0]    mem1 [1024];
    byte unsigned ref_mem [4096];
    logic [9:0]   exp_rdaddr;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mem_req_bridge #(.AWIDTH(10), .RD_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_0),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_0),
        .rsp_err(rsp_err_0), .mem_wren(mem_wren_0), .mem_wraddr(mem_wraddr_0),
        .mem_wrdata(mem_wrdata_0), .mem_wrben(mem_wrben_0),
        .mem_rdaddr(mem_rdaddr_0), .mem_rddata(mem_rddata_0)
    );

    mem_req_bridge #(.AWIDTH(10), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_1),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_1),
        .rsp_err(rsp_err_1), .mem_wren(mem_wren_1), .mem_wraddr(mem_wraddr_1),
        .mem_wrdata(mem_wrdata_1), .mem_wrben(mem_wrben_1),
        .mem_rdaddr(mem_rdaddr_1), .mem_rddata(mem_rddata_1)
    );

    // Memory models: byte-enabled writes; combinational read for dut0, flopped read for dut1.
    assign mem_rddata_0 = mem0[mem_rdaddr_0];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wren_0 && mem_wrben_0[b]) mem0[mem_wraddr_0][8*b +: 8] <= mem_wrdata_0[8*b +: 8];
            if (mem_wren_1 && mem_wrben_1[b]) mem1[mem_wraddr_1][8*b +: 8] <= mem_wrdata_1[8*b +: 8];
        end
        mem_rddata_1 <= mem1[mem_rdaddr_1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [11:0] addr, input logic [1:0] size);
        int nb;
        if (size == 2'd3) return 1'b1;
        nb = 1 << size;
        return (int'(addr[1:0]) % nb) != 0;
    endfunction

    // Little-endian read from the byte reference memory, then extension.
    function automatic logic [31:0] ref_load(input logic [11:0] addr, input logic [1:0] size, input bit uns);
        logic [63:0] v;
        int nb;
        v  = 64'd0;
        nb = 1 << size;
        for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        return v[31:0];
    endfunction

    // One full request/response transaction, starting and ending at a negedge.
    task automatic txn(input bit we, input logic [11:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wdata, input int hold);
        bit          mis;
        int          nb, lat0, lat1, exp_lat0, exp_lat1;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0]  exp_ben;
        mis      = ref_misaligned(addr, size);
        nb       = 1 << size;
        exp_rd   = (mis || we) ? 32'h0 : ref_load(addr, size, uns);
        exp_ben  = 4'b0000;
        exp_wd   = 32'h0;
        if (we && !mis) begin
            for (int i = 0; i < nb; i++) exp_ben[int'(addr[1:0]) + i] = 1'b1;
            for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wdata[8*(l % nb) +: 8];
        end
        exp_lat0 = (mis || we) ? 1 : 2;
        exp_lat1 = (mis || we) ? 1 : 3;

        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; rsp_ready = 1'b0;
        #1;
        check("req_ready0_idle", 32'(req_ready_0), 32'd1);
        check("req_ready1_idle", 32'(req_ready_1), 32'd1);
        check("wren0", 32'(mem_wren_0), 32'(we && !mis));
        check("wren1", 32'(mem_wren_1), 32'(we && !mis));
        check("wrben0", 32'(mem_wrben_0), 32'(exp_ben));
        check("wrben1", 32'(mem_wrben_1), 32'(exp_ben));
        if (we && !mis) begin
            check("wraddr0", 32'(mem_wraddr_0), 32'(addr[11:2]));
            check("wrdata0", mem_wrdata_0, exp_wd);
            check("wrdata1", mem_wrdata_1, exp_wd);
        end
        @(posedge clk);
        #1;
        if (!we && !mis) exp_rdaddr = addr[11:2];
        // Scramble the request while busy: it must be ignored.
        req_we = 1'b1; req_addr = 12'($urandom); req_size = 2'($urandom);
        req_wdata = $urandom; req_unsigned = 1'($urandom);
        lat0 = 0; lat1 = 0;
        for (int n = 1; n <= 6 && (lat0 == 0 || lat1 == 0); n++) begin
            @(negedge clk);
            if (lat0 == 0 && rsp_valid_0) lat0 = n;
            if (lat1 == 0 && rsp_valid_1) lat1 = n;
            check("busy_wren", 32'({mem_wren_0, mem_wren_1}), 32'd0);
        end
        check("latency0", 32'(lat0), 32'(exp_lat0));
        check("latency1", 32'(lat1), 32'(exp_lat1));
        check("rdaddr0", 32'(mem_rdaddr_0), 32'(exp_rdaddr));
        check("rdaddr1", 32'(mem_rdaddr_1), 32'(exp_rdaddr));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'({rsp_valid_0, rsp_valid_1}), 32'd3);
            check("hold_ready", 32'({req_ready_0, req_ready_1}), 32'd0);
            check("hold_rdata0", rsp_rdata_0, exp_rd);
            check("hold_rdata1", rsp_rdata_1, exp_rd);
        end
        check("rdata0", rsp_rdata_0, exp_rd);
        check("rdata1", rsp_rdata_1, exp_rd);
        check("err0", 32'(rsp_err_0), 32'(mis));
        check("err1", 32'(rsp_err_1), 32'(mis));
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'({rsp_valid_0, rsp_valid_1}), 32'd0);
        check("post_ready", 32'({req_ready_0, req_ready_1}), 32'd3);
        if (we && !mis) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 12'h000;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
        exp_rdaddr = 10'd0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'({req_ready_0, req_ready_1}), 32'd3);
        check("rst_rsp_valid", 32'({rsp_valid_0, rsp_valid_1}), 32'd0);
        check("rst_rsp_err", 32'({rsp_err_0, rsp_err_1}), 32'd0);
        check("rst_rdata0", rsp_rdata_0, 32'h0);
        check("rst_rdata1", rsp_rdata_1, 32'h0);
        check("rst_rdaddr", 32'({mem_rdaddr_0, mem_rdaddr_1}), 32'd0);
        check("rst_wren", 32'({mem_wren_0, mem_wren_1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 12'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 0);
        txn(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 0);
        txn(1'b1, 12'h013, 2'd0, 1'b0, 32'h0000_0080, 0);
        txn(1'b0, 12'h013, 2'd0, 1'b0, 32'h0, 0);
        txn(1'b0, 12'h013, 2'd0, 1'b1, 32'h0, 0);
        txn(1'b1, 12'h022, 2'd1, 1'b0, 32'h0000_8001, 0);
        txn(1'b0, 12'h022, 2'd1, 1'b0, 32'h0, 0);
        txn(1'b0, 12'h022, 2'd1, 1'b1, 32'h0, 0);
        txn(1'b0, 12'h021, 2'd1, 1'b0, 32'h0, 0);
        txn(1'b1, 12'h012, 2'd2, 1'b0, 32'h1234_5678, 0);
        txn(1'b0, 12'h010, 2'd3, 1'b0, 32'h0, 0);
        txn(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 5);

        // Reset while dut1 sits in RD_WAIT on a load.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h020; req_size = 2'd2;
        req_unsigned = 1'b0; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        exp_rdaddr = 10'd0;
        #1;
        check("mid_rst_valid", 32'({rsp_valid_0, rsp_valid_1}), 32'd0);
        check("mid_rst_idle", 32'({req_ready_0, req_ready_1}), 32'd3);
        check("mid_rst_rdaddr", 32'({mem_rdaddr_0, mem_rdaddr_1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", 32'({rsp_valid_0, rsp_valid_1}), 32'd0);
            check("post_rst_wren", 32'({mem_wren_0, mem_wren_1}), 32'd0);
        end
        txn(1'b1, 12'h030, 2'd2, 1'b0, 32'hCAFE_F00D, 0);
        txn(1'b0, 12'h030, 2'd2, 1'b0, 32'h0, 0);

        // Random mix over a small window so loads see earlier stores.
        for (int k = 0; k < 60; k++) begin
            txn(k < 16 ? 1'b1 : 1'($urandom), 12'h040 + 12'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
